// File: rtl/picomips_pkg.sv
// picoMIPS shared definitions: opcodes, ALU function codes, decode types.
// Imported by the decoder and the ALU.
package picomips_pkg;

  localparam int A_SIZE = 2;
  localparam int O_SIZE = 6;

  typedef logic [A_SIZE-1:0] alu_func_t;
  typedef logic [O_SIZE-1:0] opcode_t;

  localparam opcode_t NOP  = 6'h00;
  localparam opcode_t ADD  = 6'h01;
  localparam opcode_t ADDI = 6'h02;
  localparam opcode_t SUB  = 6'h03;
  localparam opcode_t SUBI = 6'h04;
  localparam opcode_t MUL  = 6'h05;
  localparam opcode_t MULI = 6'h06;
  localparam opcode_t LIR  = 6'h07;

  localparam alu_func_t RA   = 2'b00;
  localparam alu_func_t RADD = 2'b01;
  localparam alu_func_t RSUB = 2'b10;
  localparam alu_func_t RMUL = 2'b11;

endpackage

// File: rtl/picomips_decoder_sync2.sv
// Two-flop synchroniser with asynchronous active-low clear.
// Output lags the input by two rising edges.
module sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/picomips_decoder.sv
// picoMIPS instruction decoder: opcode -> ALU function, operand
// selects and PC advance; SW8 gates PC on LIR.
module picomips_decoder
  import picomips_pkg::*;
#(
  parameter int A_SIZE = picomips_pkg::A_SIZE,
  parameter int O_SIZE = picomips_pkg::O_SIZE
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic [O_SIZE-1:0] opcode,
  input  logic              SW8,
  output logic [A_SIZE-1:0] ALUfunc,
  output logic              imm,
  output logic              immswitches,
  output logic              PCincr
);

  logic      w_sw8_sync;
  logic      w_pc_en;
  alu_func_t w_func;

  sync2 u_sync2 (
    .i_clk   (clk),
    .i_rst_n (nReset),
    .i_d     (SW8),
    .o_q     (w_sw8_sync)
  );

  // Undefined and unknown opcodes fall to the NOP defaults.
  always_comb begin
    w_func      = RA;
    imm         = 1'b0;
    immswitches = 1'b0;
    w_pc_en     = 1'b1;
    case (opcode)
      ADD:  w_func = RADD;
      ADDI: begin
        w_func = RADD;
        imm    = 1'b1;
      end
      SUB:  w_func = RSUB;
      SUBI: begin
        w_func = RSUB;
        imm    = 1'b1;
      end
      MUL:  w_func = RMUL;
      MULI: begin
        w_func = RMUL;
        imm    = 1'b1;
      end
      LIR: begin
        immswitches = 1'b1;
        w_pc_en     = w_sw8_sync;
      end
      default: ;
    endcase
  end

  assign ALUfunc = w_func;
  // PC is held while reset is asserted, whatever the opcode.
  assign PCincr  = w_pc_en & nReset;

endmodule

// File: tb/tb_picomips_decoder.sv
// Directed self-checking bench for picomips_decoder.
// One task per scenario, hand-computed expectations.
module tb_picomips_decoder;
  import picomips_pkg::*;

  logic       clk;
  logic       nReset;
  logic [5:0] opcode;
  logic       SW8;
  logic [1:0] ALUfunc;
  logic       imm;
  logic       immswitches;
  logic       PCincr;

  int errors = 0;
  int checks = 0;

  picomips_decoder dut (
    .clk         (clk),
    .nReset      (nReset),
    .opcode      (opcode),
    .SW8         (SW8),
    .ALUfunc     (ALUfunc),
    .imm         (imm),
    .immswitches (immswitches),
    .PCincr      (PCincr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    checks++;
    if (imm && immswitches) begin
      errors++;
      $display("FAIL excl_sel t=%0t imm=%b immswitches=%b req not both 1",
               $time, imm, immswitches);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    SW8    = 1'b0;
    opcode = 6'h01;
    #2;
    checks++;
    if (PCincr !== 1'b0) begin
      errors++;
      $display("FAIL rst_pcincr got=%b req=0", PCincr);
    end
    checks++;
    if (ALUfunc !== 2'b01) begin
      errors++;
      $display("FAIL rst_alufunc got=%b req=01", ALUfunc);
    end
    tick();
    tick();
    nReset = 1'b1;
    #1;
    checks++;
    if (PCincr !== 1'b1) begin
      errors++;
      $display("FAIL rst_release_pcincr got=%b req=1", PCincr);
    end
  endtask

  task automatic test_stall();
    SW8    = 1'b0;
    opcode = 6'h07;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({ALUfunc, imm, immswitches, PCincr} !== 5'b00010) begin
        errors++;
        $display("FAIL stall_c%0d got=%b_%b_%b_%b req=00_0_1_0",
                 i, ALUfunc, imm, immswitches, PCincr);
      end
    end
  endtask

  task automatic test_release();
    SW8 = 1'b1;
    #1;
    checks++;
    if (PCincr !== 1'b0) begin
      errors++;
      $display("FAIL release_e0 got=%b req=0", PCincr);
    end
    tick();
    checks++;
    if (PCincr !== 1'b0) begin
      errors++;
      $display("FAIL release_e1 got=%b req=0", PCincr);
    end
    tick();
    checks++;
    if (PCincr !== 1'b1) begin
      errors++;
      $display("FAIL release_e2 got=%b req=1", PCincr);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (PCincr !== 1'b1) begin
        errors++;
        $display("FAIL release_hold%0d got=%b req=1", i, PCincr);
      end
    end
  endtask

  task automatic test_multiply();
    opcode = 6'h05;
    #1;
    checks++;
    if ({ALUfunc, imm, immswitches, PCincr} !== 5'b11001) begin
      errors++;
      $display("FAIL mul got=%b_%b_%b_%b req=11_0_0_1",
               ALUfunc, imm, immswitches, PCincr);
    end
    opcode = 6'h06;
    #1;
    checks++;
    if ({ALUfunc, imm, immswitches, PCincr} !== 5'b11101) begin
      errors++;
      $display("FAIL muli got=%b_%b_%b_%b req=11_1_0_1",
               ALUfunc, imm, immswitches, PCincr);
    end
  endtask

  task automatic test_sweep();
    logic [5:0] ops [8];
    logic [4:0] exp [8];
    ops = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h00, 6'h3F, 6'h08, 6'h07};
    exp = '{5'b01001, 5'b01101, 5'b10001, 5'b10101,
            5'b00001, 5'b00001, 5'b00001, 5'b00011};
    SW8 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      opcode = ops[i];
      #1;
      checks++;
      if ({ALUfunc, imm, immswitches, PCincr} !== exp[i]) begin
        errors++;
        $display("FAIL sweep_op%02h got=%b req=%b",
                 ops[i], {ALUfunc, imm, immswitches, PCincr}, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_lir();
    logic [3:0] exp_pc;
    SW8    = 1'b1;
    opcode = 6'h07;
    tick();
    tick();
    tick();
    checks++;
    if (PCincr !== 1'b1) begin
      errors++;
      $display("FAIL midlir_settled got=%b req=1", PCincr);
    end
    nReset = 1'b0;
    #1;
    checks++;
    if (PCincr !== 1'b0) begin
      errors++;
      $display("FAIL midlir_assert got=%b req=0", PCincr);
    end
    tick();
    nReset = 1'b1;
    #1;
    exp_pc = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (PCincr !== exp_pc[i]) begin
        errors++;
        $display("FAIL midlir_post%0d got=%b req=%b", i, PCincr, exp_pc[i]);
      end
      tick();
    end
  endtask

  initial begin
    nReset = 1'b0;
    SW8    = 1'b0;
    opcode = 6'h00;
    test_reset();
    test_stall();
    test_release();
    test_multiply();
    test_sweep();
    test_reset_mid_lir();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
